// File: rtl/apb_spi_arbiter.sv
// Two-master APB arbiter sharing one downstream APB port (SPI flash/CSR bridge).
// Define APB_SPI_ARB_RR_EN for round-robin tie-breaking; otherwise m0 has fixed priority.
module apb_spi_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  // upstream master 0
  input  logic [ADDR_W-1:0]     m0_paddr,
  input  logic                  m0_psel,
  input  logic                  m0_penable,
  input  logic [2:0]            m0_pprot,
  input  logic                  m0_pwrite,
  input  logic [DATA_W-1:0]     m0_pwdata,
  input  logic [DATA_W/8-1:0]   m0_pstrb,
  output logic                  m0_pready,
  output logic [DATA_W-1:0]     m0_prdata,
  output logic                  m0_pslverr,
  // upstream master 1
  input  logic [ADDR_W-1:0]     m1_paddr,
  input  logic                  m1_psel,
  input  logic                  m1_penable,
  input  logic [2:0]            m1_pprot,
  input  logic                  m1_pwrite,
  input  logic [DATA_W-1:0]     m1_pwdata,
  input  logic [DATA_W/8-1:0]   m1_pstrb,
  output logic                  m1_pready,
  output logic [DATA_W-1:0]     m1_prdata,
  output logic                  m1_pslverr,
  // downstream master port
  output logic [ADDR_W-1:0]     out_paddr,
  output logic                  out_psel,
  output logic                  out_penable,
  output logic [2:0]            out_pprot,
  output logic                  out_pwrite,
  output logic [DATA_W-1:0]     out_pwdata,
  output logic [DATA_W/8-1:0]   out_pstrb,
  input  logic                  out_pready,
  input  logic [DATA_W-1:0]     out_prdata,
  input  logic                  out_pslverr,
  // status
  output logic [1:0]            grant,
  output logic [1:0]            fsm_state,
  output logic [1:0]            req_waiting
);

  // Handshake: a master requests by holding psel; it is granted only when the
  // arbiter is IDLE, and its transfer ends in the cycle where the granted
  // master's pready is high (out_psel & out_penable & out_pready).

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  logic [1:0] state;
  logic [1:0] win;
  logic       tie_m1;
  logic       done;

  assign done = (state == ST_ACCESS) && out_pready;

`ifdef APB_SPI_ARB_RR_EN
  // Owner of the last completed transfer; reset to m1 so m0 wins the first tie.
  logic last_m1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_m1 <= 1'b1;
    end else if (done) begin
      last_m1 <= grant[1];
    end
  end

  assign tie_m1 = ~last_m1;
`else
  assign tie_m1 = 1'b0;
`endif

  always_comb begin
    win = 2'b00;
    if (m0_psel && m1_psel) begin
      win = tie_m1 ? 2'b10 : 2'b01;
    end else if (m0_psel) begin
      win = 2'b01;
    end else if (m1_psel) begin
      win = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      grant       <= 2'b00;
      out_paddr   <= '0;
      out_pprot   <= '0;
      out_pwrite  <= 1'b0;
      out_pwdata  <= '0;
      out_pstrb   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win != 2'b00) begin
            grant <= win;
            state <= ST_SETUP;
            if (win[1]) begin
              out_paddr  <= m1_paddr;
              out_pprot  <= m1_pprot;
              out_pwrite <= m1_pwrite;
              out_pwdata <= m1_pwdata;
              out_pstrb  <= m1_pstrb;
            end else begin
              out_paddr  <= m0_paddr;
              out_pprot  <= m0_pprot;
              out_pwrite <= m0_pwrite;
              out_pwdata <= m0_pwdata;
              out_pstrb  <= m0_pstrb;
            end
          end
        end
        ST_SETUP: begin
          state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (out_pready) begin
            state <= ST_IDLE;
            grant <= 2'b00;
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

  assign out_psel    = (state == ST_SETUP) || (state == ST_ACCESS);
  assign out_penable = (state == ST_ACCESS);

  // Response is routed only to the owner and only in the completing cycle.
  assign m0_pready  = done && grant[0];
  assign m0_prdata  = (done && grant[0]) ? out_prdata : '0;
  assign m0_pslverr = done && grant[0] && out_pslverr;
  assign m1_pready  = done && grant[1];
  assign m1_prdata  = (done && grant[1]) ? out_prdata : '0;
  assign m1_pslverr = done && grant[1] && out_pslverr;

  assign fsm_state   = state;
  // Masters sitting in their access phase while another master owns the bridge.
  assign req_waiting = {m1_psel & m1_penable & ~grant[1],
                        m0_psel & m0_penable & ~grant[0]};

endmodule

// File: tb/tb_apb_spi_arbiter.sv
// Directed + randomized bench for apb_spi_arbiter with a transaction-level model.
module tb_apb_spi_arbiter;

  logic        clk;
  logic        resetn;
  logic [31:0] m0_paddr, m1_paddr;
  logic        m0_psel, m1_psel, m0_penable, m1_penable;
  logic [2:0]  m0_pprot, m1_pprot;
  logic        m0_pwrite, m1_pwrite;
  logic [31:0] m0_pwdata, m1_pwdata;
  logic [3:0]  m0_pstrb, m1_pstrb;
  logic        m0_pready, m1_pready;
  logic [31:0] m0_prdata, m1_prdata;
  logic        m0_pslverr, m1_pslverr;
  logic [31:0] out_paddr;
  logic        out_psel, out_penable;
  logic [2:0]  out_pprot;
  logic        out_pwrite;
  logic [31:0] out_pwdata;
  logic [3:0]  out_pstrb;
  logic        out_pready;
  logic [31:0] out_prdata;
  logic        out_pslverr;
  logic [1:0]  grant;
  logic [1:0]  fsm_state;
  logic [1:0]  req_waiting;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] exp_q[$];

  apb_spi_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .m0_paddr(m0_paddr), .m0_psel(m0_psel), .m0_penable(m0_penable),
    .m0_pprot(m0_pprot), .m0_pwrite(m0_pwrite), .m0_pwdata(m0_pwdata),
    .m0_pstrb(m0_pstrb), .m0_pready(m0_pready), .m0_prdata(m0_prdata),
    .m0_pslverr(m0_pslverr),
    .m1_paddr(m1_paddr), .m1_psel(m1_psel), .m1_penable(m1_penable),
    .m1_pprot(m1_pprot), .m1_pwrite(m1_pwrite), .m1_pwdata(m1_pwdata),
    .m1_pstrb(m1_pstrb), .m1_pready(m1_pready), .m1_prdata(m1_prdata),
    .m1_pslverr(m1_pslverr),
    .out_paddr(out_paddr), .out_psel(out_psel), .out_penable(out_penable),
    .out_pprot(out_pprot), .out_pwrite(out_pwrite), .out_pwdata(out_pwdata),
    .out_pstrb(out_pstrb), .out_pready(out_pready), .out_prdata(out_prdata),
    .out_pslverr(out_pslverr),
    .grant(grant), .fsm_state(fsm_state), .req_waiting(req_waiting)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] onehot(input int m);
    return (m == 0) ? 2'b01 : 2'b10;
  endfunction

  // {pready, pslverr, prdata} seen by master m
  function automatic logic [33:0] resp(input int m);
    return (m == 0) ? {m0_pready, m0_pslverr, m0_prdata} : {m1_pready, m1_pslverr, m1_prdata};
  endfunction

  // driver tasks
  task automatic set_m(input int m, input logic sel, input logic en, input logic [31:0] a,
                       input logic w, input logic [31:0] d, input logic [3:0] s,
                       input logic [2:0] p);
    if (m == 0) begin
      m0_psel = sel; m0_penable = en; m0_paddr = a; m0_pwrite = w;
      m0_pwdata = d; m0_pstrb = s; m0_pprot = p;
    end else begin
      m1_psel = sel; m1_penable = en; m1_paddr = a; m1_pwrite = w;
      m1_pwdata = d; m1_pstrb = s; m1_pprot = p;
    end
  endtask

  task automatic set_en(input int m);
    if (m == 0) m0_penable = 1'b1;
    else        m1_penable = 1'b1;
  endtask

  // One isolated transfer from master m; the bridge inserts 'waits' wait states.
  // late_addr is driven on the upstream bus from the second cycle onward.
  task automatic do_xfer(input int m, input logic [31:0] addr, input logic wr,
                         input logic [31:0] wdata, input logic [3:0] strb,
                         input logic [2:0] prot, input int waits,
                         input logic [31:0] rdata, input logic err,
                         input logic [31:0] late_addr, input logic early_en);
    logic [1:0]  g;
    logic [33:0] r, o;
    logic        last;
    int          n_ready;
    g = onehot(m);
    @(posedge clk); #1;
    set_m(m, 1'b1, early_en, addr, wr, wdata, strb, prot);
    @(negedge clk);
    check("t0_grant", grant, 2'b00);
    check("t0_psel", out_psel, 1'b0);
    @(posedge clk); #1;
    set_m(m, 1'b1, 1'b1, late_addr, wr, wdata, strb, prot);
    @(negedge clk);
    check("setup_psel", out_psel, 1'b1);
    check("setup_penable", out_penable, 1'b0);
    check("setup_grant", grant, g);
    check("setup_paddr", out_paddr, addr);
    check("setup_pwrite", out_pwrite, wr);
    check("setup_pwdata", out_pwdata, wdata);
    check("setup_pstrb", out_pstrb, strb);
    check("setup_pprot", out_pprot, prot);
    check("setup_resp", resp(m), 34'd0);
    n_ready = 0;
    for (int i = 0; i <= waits; i++) begin
      @(posedge clk); #1;
      last        = (i == waits);
      out_pready  = last;
      out_prdata  = last ? rdata : $urandom;
      out_pslverr = last ? err : 1'($urandom_range(0, 1));
      @(negedge clk);
      r = resp(m);
      o = resp(1 - m);
      check("acc_psel", {out_psel, out_penable}, 2'b11);
      check("acc_grant", grant, g);
      check("acc_paddr", out_paddr, addr);
      check("acc_pwdata", out_pwdata, wdata);
      check("acc_pstrb", out_pstrb, strb);
      check("acc_pready", r[33], last);
      check("acc_pslverr", r[32], last ? err : 1'b0);
      check("acc_prdata", r[31:0], last ? rdata : 32'd0);
      check("other_resp", o, 34'd0);
      n_ready += int'(r[33]);
    end
    check("ready_count", n_ready, 1);
    @(posedge clk); #1;
    set_m(m, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 3'd0);
    out_pready = 1'b0; out_prdata = 32'd0; out_pslverr = 1'b0;
    @(negedge clk);
    check("end_grant", grant, 2'b00);
    check("end_psel", {out_psel, out_penable}, 2'b00);
  endtask

  initial begin : main
    int          rem[2];
    logic        in_xfer[2];
    logic        prev_done;
    int          cyc;
    int          p0, p1, lastw, w;
    logic [33:0] r;
    logic [1:0]  e;

    resetn = 1'b0;
    set_m(0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 3'd0);
    set_m(1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 3'd0);
    out_pready = 1'b0; out_prdata = 32'd0; out_pslverr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_grant", grant, 2'b00);
    check("rst_psel", {out_psel, out_penable}, 2'b00);
    check("rst_req", {out_paddr, out_pwdata}, 64'd0);
    check("rst_misc", {out_pprot, out_pwrite, out_pstrb}, 8'd0);
    check("rst_m0", resp(0), 34'd0);
    check("rst_m1", resp(1), 34'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // single m0 read, zero wait states
    do_xfer(0, 32'h3000_0010, 1'b0, 32'd0, 4'h0, 3'd0, 0, 32'hDEAD_BEEF, 1'b0,
            32'h3000_0010, 1'b0);
    // m1 write with a long stall
    do_xfer(1, 32'h1000_0014, 1'b1, 32'h0000_0003, 4'hF, 3'd2, 40, 32'd0, 1'b0,
            32'h1000_0014, 1'b0);
    // slave error on an m0 write, then a clean transfer
    do_xfer(0, 32'h3000_0020, 1'b1, 32'hA5A5_5A5A, 4'h3, 3'd1, 1, 32'd0, 1'b1,
            32'h3000_0020, 1'b0);
    do_xfer(0, 32'h3000_0024, 1'b0, 32'd0, 4'h0, 3'd0, 0, 32'h1234_5678, 1'b0,
            32'h3000_0024, 1'b0);
    // upstream address changes mid-transfer
    do_xfer(0, 32'h3000_0000, 1'b0, 32'd0, 4'h0, 3'd0, 2, 32'h0BAD_F00D, 1'b0,
            32'h3000_0100, 1'b0);
    // random single-master transfers; one arrives with penable already high
    for (int k = 0; k < 6; k++) begin
      logic [31:0] a;
      a = $urandom;
      do_xfer(int'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)), $urandom,
              4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
              int'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)), a,
              (k == 2));
    end

    // reference order for 4+4 simultaneous requests
    p0 = 4; p1 = 4; lastw = 1;
    while (p0 + p1 > 0) begin
      if (p0 > 0 && p1 > 0) begin
`ifdef APB_SPI_ARB_RR_EN
        w = 1 - lastw;
`else
        w = 0;
`endif
      end else begin
        w = (p0 > 0) ? 0 : 1;
      end
      if (w == 0) p0--; else p1--;
      lastw = w;
      exp_q.push_back(onehot(w));
    end

    rem[0] = 4; rem[1] = 4;
    in_xfer[0] = 1'b0; in_xfer[1] = 1'b0;
    prev_done = 1'b0;
    cyc = 0;
    while ((rem[0] > 0 || rem[1] > 0) && cyc < 300) begin
      cyc++;
      @(posedge clk); #1;
      for (int m = 0; m < 2; m++) begin
        if (rem[m] == 0)
          set_m(m, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 3'd0);
        else if (!in_xfer[m])
          set_m(m, 1'b1, 1'b0, $urandom, 1'($urandom_range(0, 1)), $urandom, 4'hF, 3'd0);
        else
          set_en(m);
      end
      out_pready  = 1'($urandom_range(0, 1));
      out_prdata  = $urandom;
      out_pslverr = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("tie_one_ready", m0_pready & m1_pready, 1'b0);
      if (prev_done) check("tie_idle_gap", out_psel, 1'b0);
      prev_done = 1'b0;
      for (int m = 0; m < 2; m++) begin
        r = resp(m);
        if (r[33]) begin
          if (exp_q.size() == 0) begin
            check("tie_extra", 1'b1, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check("tie_order", onehot(m), e);
          end
          check("tie_grant", grant, onehot(m));
          check("tie_prdata", r[31:0], out_prdata);
          check("tie_pslverr", r[32], out_pslverr);
          rem[m]--;
          in_xfer[m] = 1'b0;
          prev_done = 1'b1;
        end else begin
          check("tie_quiet", r, 34'd0);
          in_xfer[m] = (rem[m] > 0);
        end
      end
    end
    check("tie_all_done", rem[0] + rem[1], 0);
    check("tie_order_left", exp_q.size(), 0);
    @(posedge clk); #1;
    set_m(0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 3'd0);
    set_m(1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 3'd0);
    out_pready = 1'b0; out_prdata = 32'd0; out_pslverr = 1'b0;
    repeat (2) @(posedge clk);

    // asynchronous reset while the bridge stalls an m0 access
    #1;
    set_m(0, 1'b1, 1'b0, 32'h3000_0040, 1'b0, 32'd0, 4'd0, 3'd0);
    @(posedge clk); #1;
    set_en(0);
    @(posedge clk); #1;
    @(negedge clk);
    check("stall_access", {out_psel, out_penable}, 2'b11);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_psel", {out_psel, out_penable}, 2'b00);
    check("arst_grant", grant, 2'b00);
    check("arst_m0", resp(0), 34'd0);
    @(posedge clk); #1;
    set_m(0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 3'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    do_xfer(1, 32'h1000_0008, 1'b0, 32'd0, 4'h0, 3'd0, 1, 32'hCAFE_0001, 1'b0,
            32'h1000_0008, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
